// File: rtl/pcc_err_eval.sv
// pcc_err_eval: exhaustive error evaluator for approximate popcount-compare circuits.
//
// Sweeps every pos/neg combination into the circuit under evaluation, waits DUT_LAT
// cycles for its decision, and compares that decision against the exact result
// popcount(pos) >= popcount(neg). Mismatches are tallied as total, false-positive
// and false-negative counts.
//
// Parameters:
//   NPOS    - width of the positive vector
//   NNEG    - width of the negative vector
//   DUT_LAT - circuit latency in cycles (0..3, 0 = combinational)
//
// Ports:
//   clk, rst       - clock, synchronous active-high reset
//   start          - begin a sweep (accepted only while idle)
//   pos, neg       - vectors driven to the circuit
//   outval         - circuit decision
//   busy           - sweep in progress (run or drain)
//   done           - one-cycle pulse, counters final
//   err_cnt        - total mismatches
//   fp_cnt, fn_cnt - mismatches with outval=1/exact=0 and outval=0/exact=1
//
// Optional feature, macro PCC_EVAL_FIRST_ERR_EN:
//   first_err_idx, first_err_vld - vector index of the first mismatch in the sweep
module pcc_err_eval #(
   parameter int unsigned NPOS    = 2,
   parameter int unsigned NNEG    = 4,
   parameter int unsigned DUT_LAT = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   output logic [NPOS-1:0]      pos,
   output logic [NNEG-1:0]      neg,
   input  logic                 outval,
   output logic                 busy,
   output logic                 done,
   output logic [NPOS+NNEG:0]   err_cnt,
   output logic [NPOS+NNEG:0]   fp_cnt,
`ifdef PCC_EVAL_FIRST_ERR_EN
   output logic [NPOS+NNEG:0]   fn_cnt,
   output logic [NPOS+NNEG-1:0] first_err_idx,
   output logic                 first_err_vld
`else
   output logic [NPOS+NNEG:0]   fn_cnt
`endif
);

   localparam int unsigned N         = NPOS + NNEG;
   localparam int unsigned CntW      = N + 1;
   localparam int unsigned PcMax     = (NPOS > NNEG) ? NPOS : NNEG;
   localparam int unsigned PcW       = $clog2(PcMax + 1);
   localparam int unsigned DrainLast = (DUT_LAT > 0) ? DUT_LAT - 1 : 0;

   typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

   state_e          state_q, state_d;
   logic [N-1:0]    vec_q, vec_d;
   logic [1:0]      drain_q, drain_d;
   logic [CntW-1:0] err_q, err_d;
   logic [CntW-1:0] fp_q, fp_d;
   logic [CntW-1:0] fn_q, fn_d;

   logic [PcW-1:0]  pc_pos, pc_neg;
   logic            exp_now;
   logic            run_now;
   logic            accept;
   logic            vec_last;
   logic            cmp_vld;
   logic            cmp_exp;
   logic            mismatch;

`ifdef PCC_EVAL_FIRST_ERR_EN
   logic [N-1:0]    cmp_idx;
   logic [N-1:0]    fe_idx_q, fe_idx_d;
   logic            fe_vld_q, fe_vld_d;
`endif

   assign run_now  = (state_q == StRun);
   assign accept   = (state_q == StIdle) && start;
   assign vec_last = (vec_q == {N{1'b1}});

   // Exact reference for the vector currently driven.
   always_comb begin
      pc_pos = '0;
      pc_neg = '0;
      for (int i = 0; i < NPOS; i++) pc_pos = pc_pos + PcW'(vec_q[i]);
      for (int i = 0; i < NNEG; i++) pc_neg = pc_neg + PcW'(vec_q[NPOS+i]);
      exp_now = (pc_pos >= pc_neg);
   end

   // Expected bit, valid flag (and index) delayed to line up with outval.
   generate
      if (DUT_LAT == 0) begin : g_no_lat
         assign cmp_vld = run_now;
         assign cmp_exp = exp_now;
`ifdef PCC_EVAL_FIRST_ERR_EN
         assign cmp_idx = vec_q;
`endif
      end else begin : g_lat
         logic [DUT_LAT-1:0] vld_q, vld_d;
         logic [DUT_LAT-1:0] exp_q, exp_d;
`ifdef PCC_EVAL_FIRST_ERR_EN
         logic [N-1:0] idx_q [DUT_LAT];
         logic [N-1:0] idx_d [DUT_LAT];
`endif

         always_comb begin
            vld_d[0] = run_now;
            exp_d[0] = exp_now;
`ifdef PCC_EVAL_FIRST_ERR_EN
            idx_d[0] = vec_q;
`endif
            for (int i = 1; i < DUT_LAT; i++) begin
               vld_d[i] = vld_q[i-1];
               exp_d[i] = exp_q[i-1];
`ifdef PCC_EVAL_FIRST_ERR_EN
               idx_d[i] = idx_q[i-1];
`endif
            end
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               vld_q <= '0;
               exp_q <= '0;
            end else begin
               vld_q <= vld_d;
               exp_q <= exp_d;
            end
`ifdef PCC_EVAL_FIRST_ERR_EN
            // Index is qualified by vld_q, so it needs no reset.
            for (int i = 0; i < DUT_LAT; i++) idx_q[i] <= idx_d[i];
`endif
         end

         assign cmp_vld = vld_q[DUT_LAT-1];
         assign cmp_exp = exp_q[DUT_LAT-1];
`ifdef PCC_EVAL_FIRST_ERR_EN
         assign cmp_idx = idx_q[DUT_LAT-1];
`endif
      end
   endgenerate

   assign mismatch = cmp_vld && (outval != cmp_exp);

   // FSM: state register
   always_ff @(posedge clk) begin
      if (rst) state_q <= StIdle;
      else     state_q <= state_d;
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (start) state_d = StRun;
         StRun:   if (vec_last) state_d = (DUT_LAT > 0) ? StDrain : StDone;
         StDrain: if (drain_q == 2'(DrainLast)) state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // FSM: outputs
   always_comb begin
      busy = (state_q == StRun) || (state_q == StDrain);
      done = (state_q == StDone);
   end

   // Datapath next state
   always_comb begin
      vec_d   = vec_q;
      drain_d = '0;
      err_d   = err_q;
      fp_d    = fp_q;
      fn_d    = fn_q;
`ifdef PCC_EVAL_FIRST_ERR_EN
      fe_idx_d = fe_idx_q;
      fe_vld_d = fe_vld_q;
`endif
      if (accept) begin
         vec_d = '0;
         err_d = '0;
         fp_d  = '0;
         fn_d  = '0;
`ifdef PCC_EVAL_FIRST_ERR_EN
         fe_idx_d = '0;
         fe_vld_d = 1'b0;
`endif
      end else begin
         // The last vector is held through drain, so vec never wraps.
         if (run_now && !vec_last) vec_d = vec_q + N'(1);
         if (state_q == StDrain) drain_d = drain_q + 2'd1;
         if (mismatch) begin
            err_d = err_q + CntW'(1);
            if (outval) fp_d = fp_q + CntW'(1);
            else        fn_d = fn_q + CntW'(1);
`ifdef PCC_EVAL_FIRST_ERR_EN
            if (!fe_vld_q) begin
               fe_idx_d = cmp_idx;
               fe_vld_d = 1'b1;
            end
`endif
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vec_q   <= '0;
         drain_q <= '0;
         err_q   <= '0;
         fp_q    <= '0;
         fn_q    <= '0;
`ifdef PCC_EVAL_FIRST_ERR_EN
         fe_idx_q <= '0;
         fe_vld_q <= 1'b0;
`endif
      end else begin
         vec_q   <= vec_d;
         drain_q <= drain_d;
         err_q   <= err_d;
         fp_q    <= fp_d;
         fn_q    <= fn_d;
`ifdef PCC_EVAL_FIRST_ERR_EN
         fe_idx_q <= fe_idx_d;
         fe_vld_q <= fe_vld_d;
`endif
      end
   end

   assign pos     = vec_q[NPOS-1:0];
   assign neg     = vec_q[N-1:NPOS];
   assign err_cnt = err_q;
   assign fp_cnt  = fp_q;
   assign fn_cnt  = fn_q;
`ifdef PCC_EVAL_FIRST_ERR_EN
   assign first_err_idx = fe_idx_q;
   assign first_err_vld = fe_vld_q;
`endif

endmodule

// File: tb/tb_pcc_err_eval.sv
// Directed bench for pcc_err_eval: one instance with DUT_LAT=0 driving a combinational
// circuit model, one with DUT_LAT=2 driving the same model registered twice.
module tb_pcc_err_eval;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   int         mode;   // 0 exact circuit, 1 constant 1, 2 constant 0

   logic [1:0] pos0, pos2;
   logic [3:0] neg0, neg2;
   logic       outval0, outval2;
   logic       busy0, busy2, done0, done2;
   logic [6:0] err0, fp0, fn0, err2, fp2, fn2;
`ifdef PCC_EVAL_FIRST_ERR_EN
   logic [5:0] fei0, fei2;
   logic       fev0, fev2;
`endif

   logic       r1, r2;

   int errors = 0;
   int checks = 0;

   int d0_cyc, d2_cyc, n_done0, n_done2;
   int b0_first, b0_last, b2_first, b2_last;

   always #5 clk = ~clk;

   function automatic logic exact_ref(input logic [1:0] p, input logic [3:0] n);
      return $countones(p) >= $countones(n);
   endfunction

   always_comb begin
      outval0 = 1'b0;
      if (mode == 0)      outval0 = exact_ref(pos0, neg0);
      else if (mode == 1) outval0 = 1'b1;
   end

   always @(posedge clk) begin
      r1 <= exact_ref(pos2, neg2);
      r2 <= r1;
   end

   always_comb begin
      outval2 = 1'b0;
      if (mode == 0)      outval2 = r2;
      else if (mode == 1) outval2 = 1'b1;
   end

   pcc_err_eval #(.NPOS(2), .NNEG(4), .DUT_LAT(0)) dut0 (
      .clk(clk), .rst(rst), .start(start), .pos(pos0), .neg(neg0), .outval(outval0),
      .busy(busy0), .done(done0), .err_cnt(err0), .fp_cnt(fp0),
`ifdef PCC_EVAL_FIRST_ERR_EN
      .fn_cnt(fn0), .first_err_idx(fei0), .first_err_vld(fev0)
`else
      .fn_cnt(fn0)
`endif
   );

   pcc_err_eval #(.NPOS(2), .NNEG(4), .DUT_LAT(2)) dut2 (
      .clk(clk), .rst(rst), .start(start), .pos(pos2), .neg(neg2), .outval(outval2),
      .busy(busy2), .done(done2), .err_cnt(err2), .fp_cnt(fp2),
`ifdef PCC_EVAL_FIRST_ERR_EN
      .fn_cnt(fn2), .first_err_idx(fei2), .first_err_vld(fev2)
`else
      .fn_cnt(fn2)
`endif
   );

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Start a sweep at edge 0 and watch a fixed 75 cycles; c is the cycle number.
   // inj > 0 pulses start again during that cycle.
   task automatic run_sweep(input int inj);
      d0_cyc = -1; d2_cyc = -1; n_done0 = 0; n_done2 = 0;
      b0_first = -1; b0_last = -1; b2_first = -1; b2_last = -1;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int c = 1; c <= 75; c++) begin
         @(negedge clk);
         start = (c == inj);
         if (done0) begin n_done0++; d0_cyc = c; end
         if (done2) begin n_done2++; d2_cyc = c; end
         if (busy0) begin if (b0_first < 0) b0_first = c; b0_last = c; end
         if (busy2) begin if (b2_first < 0) b2_first = c; b2_last = c; end
      end
      start = 1'b0;
   endtask

   task automatic check_counts(input string tag, input int e, input int fp, input int fn);
      check({tag, "_err0"}, int'(err0), e);
      check({tag, "_fp0"},  int'(fp0),  fp);
      check({tag, "_fn0"},  int'(fn0),  fn);
      check({tag, "_err2"}, int'(err2), e);
      check({tag, "_fp2"},  int'(fp2),  fp);
      check({tag, "_fn2"},  int'(fn2),  fn);
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      mode  = 0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);

      // Reset state
      check("rst_busy0", int'(busy0), 0);
      check("rst_done0", int'(done0), 0);
      check("rst_pos0",  int'(pos0),  0);
      check("rst_neg0",  int'(neg0),  0);
      check("rst_busy2", int'(busy2), 0);
      check_counts("rst", 0, 0, 0);
`ifdef PCC_EVAL_FIRST_ERR_EN
      check("rst_fev0", int'(fev0), 0);
      check("rst_fei0", int'(fei0), 0);
`endif

      // Exact circuit: no errors, timing for both latencies
      mode = 0;
      run_sweep(0);
      check("exact_done_cyc0", d0_cyc, 65);
      check("exact_done_n0",   n_done0, 1);
      check("exact_busy_first0", b0_first, 1);
      check("exact_busy_last0",  b0_last, 64);
      check("exact_done_cyc2", d2_cyc, 67);
      check("exact_done_n2",   n_done2, 1);
      check("exact_busy_first2", b2_first, 1);
      check("exact_busy_last2",  b2_last, 66);
      check_counts("exact", 0, 0, 0);
`ifdef PCC_EVAL_FIRST_ERR_EN
      check("exact_fev0", int'(fev0), 0);
`endif

      // Constant 1: 42 false positives, first at vector 4
      mode = 1;
      run_sweep(0);
      check("c1_done_cyc0", d0_cyc, 65);
      check_counts("c1", 42, 42, 0);
`ifdef PCC_EVAL_FIRST_ERR_EN
      check("c1_fei0", int'(fei0), 4);
      check("c1_fev0", int'(fev0), 1);
      check("c1_fei2", int'(fei2), 4);
      check("c1_fev2", int'(fev2), 1);
`endif

      // Constant 0: 22 false negatives, first at vector 0
      mode = 2;
      run_sweep(0);
      check_counts("c0", 22, 0, 22);
`ifdef PCC_EVAL_FIRST_ERR_EN
      check("c0_fei0", int'(fei0), 0);
`endif

      // start pulsed mid-RUN is ignored
      mode = 0;
      run_sweep(20);
      check("ign_done_cyc0", d0_cyc, 65);
      check("ign_done_n0",   n_done0, 1);
      check("ign_done_n2",   n_done2, 1);

      // Reset mid-sweep at cycle 30, then a full clean sweep
      mode = 1;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (30) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("midrst_busy0", int'(busy0), 0);
      check("midrst_busy2", int'(busy2), 0);
      check("midrst_pos0",  int'(pos0),  0);
      check("midrst_neg0",  int'(neg0),  0);
      check_counts("midrst", 0, 0, 0);
      mode = 2;
      run_sweep(0);
      check("post_done_cyc0", d0_cyc, 65);
      check("post_done_cyc2", d2_cyc, 67);
      check_counts("post", 22, 0, 22);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
